// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM transmit/receive path.
package tdm_pkg;
  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} tdm_state_t;

  function automatic logic [NCH-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    logic [NCH-1:0] one;
    one = {{(NCH-1){1'b0}}, 1'b1};
    return one << s;
  endfunction
endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-4 slot counter with increment enable and load-to-1 (load wins).
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load1_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = SLOT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: HUNT/CHECK/LOCK framer steering serial bits into held outputs.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              d,
  input  logic              sync,
  output logic [NCH-1:0]    z,
  output logic [NCH-1:0]    upd,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              err
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  tdm_state_t        state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [NCH-1:0]    z_q, z_d;
  logic [NCH-1:0]    upd_q, upd_d;
  logic              err_q, err_d;

  logic [SLOT_W-1:0] cnt;
  logic [SLOT_W-1:0] cap_slot;
  logic              capture;
  logic              ctr_inc;
  logic              ctr_load1;
  logic              mismatch;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ctr_inc),
    .load1_i (ctr_load1),
    .cnt_o   (cnt)
  );

  // sync must be high exactly in slot 0
  assign mismatch = sync ^ (cnt == '0);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_d     = 1'b0;
    ctr_inc   = 1'b0;
    ctr_load1 = 1'b0;
    capture   = 1'b0;
    cap_slot  = cnt;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            ctr_load1 = 1'b1;
            good_d    = GOOD_W'(1);
            if (LOCK_FRAMES == 1) begin
              state_d  = LOCK;
              capture  = 1'b1;
              cap_slot = '0;
            end else begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (sync && (cnt != '0)) begin
            ctr_load1 = 1'b1;
            good_d    = GOOD_W'(1);
          end else begin
            ctr_inc = 1'b1;
            if (cnt == '0) begin
              if (sync) begin
                good_d = good_q + 1'b1;
                if (int'(good_q) + 1 == LOCK_FRAMES) begin
                  state_d  = LOCK;
                  capture  = 1'b1;
                  cap_slot = '0;
                end
              end else begin
                state_d = HUNT;
              end
            end
          end
        end
        LOCK: begin
          if (mismatch) begin
            err_d   = 1'b1;
            state_d = HUNT;
            good_d  = '0;
          end else begin
            ctr_inc = 1'b1;
            capture = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign upd_d = capture ? slot_onehot(cap_slot) : '0;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign z_d[gi] = (capture && (cap_slot == SLOT_W'(gi))) ? d : z_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      good_q  <= '0;
      z_q     <= '0;
      upd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      z_q     <= z_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign z      = z_q;
  assign upd    = upd_q;
  assign slot   = cnt;
  assign locked = (state_q == LOCK);
  assign err    = err_q;

endmodule
